// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store port and a DMA port.
// The core has fixed priority, with a starvation-forced DMA beat and a bounded DMA burst lock.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   S_CORE | unlocked; core wins contention unless DMA has waited MAX_WAIT cycles
//   S_DMA  | DMA burst lock held; core stalls until last beat, cap or DMA gap
module dmem_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_gnt,
    output logic        c_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_last,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_gnt,
    output logic        m_we,
    output logic        m_en,
    output logic [31:0] m_addr,
    output logic [31:0] m_wd,
    input  logic [31:0] m_rd
);

    typedef enum logic {S_CORE = 1'b0, S_DMA = 1'b1} state_t;

    localparam logic [3:0] WAIT_MAX   = 4'(MAX_WAIT);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic       CAN_LOCK   = (MAX_BURST > 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic [7:0] burst_cnt;
    logic       forced;

    assign forced = d_req & (wait_cnt == WAIT_MAX);

    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst) begin
            case (state)
                S_CORE: begin
                    if (c_req && !forced) begin
                        c_gnt = 1'b1;
                    end else begin
                        d_gnt = d_req;
                    end
                end
                S_DMA: begin
                    d_gnt = d_req;
                end
                default: begin
                    c_gnt = 1'b0;
                    d_gnt = 1'b0;
                end
            endcase
        end
    end

    assign c_stall = rst & c_req & ~c_gnt;

    // Idle bus drives zeros so data_mem never sees a stale address or data.
    always_comb begin
        m_we   = 1'b0;
        m_en   = 1'b0;
        m_addr = 32'h0;
        m_wd   = 32'h0;
        if (c_gnt) begin
            m_we   = c_we;
            m_en   = ~c_we;
            m_addr = c_addr;
            m_wd   = c_wdata;
        end else if (d_gnt) begin
            m_we   = d_we;
            m_en   = ~d_we;
            m_addr = d_addr;
            m_wd   = d_wdata;
        end
    end

    assign c_rdata = m_rd;
    assign d_rdata = m_rd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_CORE;
            wait_cnt  <= 4'd0;
            burst_cnt <= 8'd0;
        end else begin
            if (d_gnt || !d_req) begin
                wait_cnt <= 4'd0;
            end else if (state == S_CORE && c_req && c_gnt && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            case (state)
                S_CORE: begin
                    // A single-beat grant (d_last) or MAX_BURST of 1 never takes the lock.
                    if (d_gnt && !d_last && CAN_LOCK) begin
                        state     <= S_DMA;
                        burst_cnt <= 8'd1;
                    end
                end
                S_DMA: begin
                    if (!d_req) begin
                        state     <= S_CORE;
                        burst_cnt <= 8'd0;
                    end else if (d_last || burst_cnt == BURST_LAST) begin
                        state     <= S_CORE;
                        burst_cnt <= 8'd0;
                    end else begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= S_CORE;
                    burst_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed test-plan sequences plus randomized traffic,
// checked against a transaction-level model of the arbitration rules and a memory model.
module tb_dmem_arbiter;

    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we, d_last;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [31:0] c_rdata, d_rdata, m_addr, m_wd, m_rd;
    logic        c_gnt, c_stall, d_gnt, m_we, m_en;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_gnt(c_gnt), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_last(d_last), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_gnt(d_gnt),
        .m_we(m_we), .m_en(m_en), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd)
    );

    // data_mem stand-in: asynchronous read, write at the edge ending the granted cycle
    logic [31:0] mem [0:63];
    assign m_rd = mem[m_addr[7:2]];
    always @(posedge clk) if (m_we) mem[m_addr[7:2]] <= m_wd;

    typedef struct {
        logic        cg, dg, cs, we, en;
        logic [31:0] addr, wd, rd;
        logic        chk_rd, rd_core;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model: lock flag, beats taken under the lock, contended cycles lost
    bit          mdl_locked = 0;
    int          mdl_beats  = 0;
    int          mdl_waited = 0;
    logic [31:0] ref_mem [0:63];
    bit          last_cg = 0, last_dg = 0;

    task automatic cyc(input logic r, input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic dl,
                       input logic [31:0] da, input logic [31:0] dd);
        exp_t e;
        bit cg, dg;
        @(negedge clk);
        rst = r; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_last = dl; d_addr = da; d_wdata = dd;
        cg = 0; dg = 0;
        if (r) begin
            if (mdl_locked) dg = dr;
            else if (cr && !(dr && mdl_waited >= MAX_WAIT)) cg = 1;
            else dg = dr;
        end
        e.cg = cg; e.dg = dg; e.cs = r & cr & ~cg;
        e.we = 0; e.en = 0; e.addr = 0; e.wd = 0; e.rd = 0; e.chk_rd = 0; e.rd_core = cg;
        if (cg) begin e.we = cw; e.en = ~cw; e.addr = ca; e.wd = cd; end
        if (dg) begin e.we = dw; e.en = ~dw; e.addr = da; e.wd = dd; end
        if ((cg || dg) && !e.we) begin e.chk_rd = 1; e.rd = ref_mem[e.addr[7:2]]; end
        expq.push_back(e);
        if ((cg || dg) && e.we) ref_mem[e.addr[7:2]] = e.wd;
        if (!r) begin
            mdl_locked = 0; mdl_beats = 0; mdl_waited = 0;
        end else begin
            if (dg) begin
                mdl_beats = mdl_locked ? mdl_beats + 1 : 1;
                if (dl || mdl_beats >= MAX_BURST) begin mdl_locked = 0; mdl_beats = 0; end
                else mdl_locked = 1;
            end else if (mdl_locked) begin
                mdl_locked = 0; mdl_beats = 0;
            end
            if (dg || !dr) mdl_waited = 0;
            else if (cg && mdl_waited < MAX_WAIT) mdl_waited++;
        end
        last_cg = cg; last_dg = dg;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: pops one expectation per presented cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("grant/stall", {29'd0, c_gnt, d_gnt, c_stall}, {29'd0, e.cg, e.dg, e.cs});
                chk("m_we/m_en", {30'd0, m_we, m_en}, {30'd0, e.we, e.en});
                chk("m_addr", m_addr, e.addr);
                chk("m_wd", m_wd, e.wd);
                if (e.chk_rd) chk("rdata", e.rd_core ? c_rdata : d_rdata, e.rd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit cr, cw, dr, dw, dl, r;
        logic [31:0] ca, cd, da, dd;
        int run, maxrun;
        for (int i = 0; i < 64; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        rst = 0; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_last = 0; d_addr = 0; d_wdata = 0;

        // reset holds everything off even with both requesting
        cyc(0, 1, 1, 32'h4, 32'h1, 1, 1, 1, 32'h8, 32'h2);
        #3;
        chk("reset grants", {30'd0, c_gnt, d_gnt}, 32'd0);
        chk("reset mem ctl", {29'd0, m_we, m_en, c_stall}, 32'd0);
        cyc(1, 1, 0, 32'h4, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        #3;
        chk("first core gnt", {31'd0, c_gnt}, 32'd1);

        // core write then read back
        cyc(1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0);
        #3;
        chk("core write m_we", {31'd0, m_we}, 32'd1);
        cyc(1, 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        #3;
        chk("core readback", c_rdata, 32'hDEADBEEF);
        chk("core read gnt/stall", {30'd0, c_gnt, c_stall}, 32'd2);

        // starvation: one forced DMA beat every MAX_WAIT+1 cycles
        for (int i = 0; i < 15; i++) begin
            cyc(1, 1, 0, 32'h20, 32'h0, 1, 0, 1, 32'h24, 32'h0);
            #3;
            chk("starve d_gnt", {31'd0, d_gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
            chk("starve c_stall", {31'd0, c_stall}, (i % 5 == 4) ? 32'd1 : 32'd0);
        end

        // three-beat DMA burst holds the lock against the core
        for (int i = 0; i < 4; i++) begin
            cyc(1, i != 0, 0, 32'h30, 32'h0, i < 3, 1, i == 2, 32'h40 + 32'(i * 4), 32'hA0 + 32'(i));
            #3;
            chk("burst d_gnt", {31'd0, d_gnt}, (i < 3) ? 32'd1 : 32'd0);
            chk("burst c_gnt/stall", {30'd0, c_gnt, c_stall},
                (i == 0) ? 32'd0 : (i < 3) ? 32'd1 : 32'd2);
        end

        // burst cap: 4 core cycles, then 8 DMA beats, repeating
        run = 0; maxrun = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(1, 1, 0, 32'h50, 32'h0, 1, 1, 0, 32'h60, 32'h5A5A0000 + 32'(i));
            #3;
            chk("cap d_gnt", {31'd0, d_gnt}, ((i % 12) >= 4) ? 32'd1 : 32'd0);
            run = d_gnt ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("cap run length", 32'(maxrun), 32'd8);

        // reset in the middle of a burst drops the lock
        cyc(1, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h70, 32'h0);
        cyc(1, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h74, 32'h0);
        cyc(0, 1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h78, 32'h0);
        cyc(1, 1, 0, 32'h80, 32'h0, 1, 0, 0, 32'h78, 32'h0);
        #3;
        chk("post-reset counters", {20'd0, dut.wait_cnt, dut.burst_cnt}, 32'd0);
        chk("post-reset core wins", {30'd0, c_gnt, d_gnt}, 32'd2);

        // randomized traffic; requesters hold their request until granted
        cr = 0; dr = 0; cw = 0; dw = 0; dl = 0; ca = 0; cd = 0; da = 0; dd = 0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 99) != 0);
            if (!(cr && !last_cg)) begin
                cr = ($urandom_range(0, 2) != 0); cw = $urandom_range(0, 1) == 1;
                ca = $urandom & 32'h0000_03FC; cd = $urandom;
            end
            if (!(dr && !last_dg)) begin
                dr = ($urandom_range(0, 3) != 0); dw = $urandom_range(0, 1) == 1;
                dl = ($urandom_range(0, 5) == 0);
                da = $urandom & 32'h0000_03FC; dd = $urandom;
            end
            cyc(r, cr, cw, ca, cd, dr, dw, dl, da, dd);
        end

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
